vec_inst_dispatch: RTL and testbench

Scalar-side dispatch stage directly upstream of the vector processor. It buffers vector instructions and their rs1/rs2 operands from the scalar pipeline in a small FIFO. It drives them one at a time over the vector processor's inst_valid / vec_pro_ready handshake, and waits for vec_pro_ack before issuing the next, so at most one instruction is in flight. It returns a per-instruction completion response (error, illegal, timeout) to the scalar core.

---
 rtl/vec_inst_dispatch.sv | 226 ++++++++++++++++++++++
 tb/tb_vec_inst_dispatch.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_inst_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : vec_inst_dispatch
//  Description : Buffers vector instructions and operands from the scalar
//                core, issues them one at a time to the vector processor and
//                returns a completion response for each.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_inst_dispatch #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [XLEN-1:0]        enq_instruction,
    input  logic [XLEN-1:0]        enq_rs1_data,
    input  logic [XLEN-1:0]        enq_rs2_data,
    input  logic                   flush,
    output logic                   inst_valid,
    output logic [XLEN-1:0]        instruction,
    output logic [XLEN-1:0]        rs1_data,
    output logic [XLEN-1:0]        rs2_data,
    input  logic                   vec_pro_ready,
    input  logic                   vec_pro_ack,
    input  logic                   is_vec,
    input  logic                   error,
    output logic                   scalar_pro_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_error,
    output logic                   resp_illegal,
    output logic                   resp_timeout,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_TW = $clog2(TIMEOUT) + 1;
    localparam int c_EW = 3 * XLEN;

    localparam logic [c_CW-1:0] c_FULL     = c_CW'(DEPTH);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ISSUE    = 2'd1;
    localparam logic [1:0] c_WAIT_ACK = 2'd2;
    localparam logic [1:0] c_RESP     = 2'd3;

    logic [1:0]      state_q,  state_d;
    logic [c_EW-1:0] mem_q [DEPTH];
    logic [c_EW-1:0] mem_d [DEPTH];
    logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CW-1:0] count_q,  count_d;
    logic [c_TW-1:0] timer_q,  timer_d;
    logic [XLEN-1:0] instr_q,  instr_d;
    logic [XLEN-1:0] rs1_q,    rs1_d;
    logic [XLEN-1:0] rs2_q,    rs2_d;
    logic            resp_error_q,   resp_error_d;
    logic            resp_illegal_q, resp_illegal_d;
    logic            resp_timeout_q, resp_timeout_d;

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_ack;
    logic w_expire;

    // A flush drops any same-cycle push and blocks the pop out of IDLE.
    assign w_full   = (count_q == c_FULL);
    assign w_push   = enq_valid && !w_full && !flush;
    assign w_pop    = (state_q == c_IDLE) && (count_q != '0) && !flush;
    assign w_ack    = (state_q == c_WAIT_ACK) && vec_pro_ack;
    assign w_expire = (state_q == c_WAIT_ACK) && (timer_q == c_TMO_LAST);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_pop) begin
                    state_d = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (vec_pro_ready) begin
                    state_d = c_WAIT_ACK;
                end
            end
            c_WAIT_ACK: begin
                if (vec_pro_ack || w_expire) begin
                    state_d = c_RESP;
                end
            end
            c_RESP: begin
                if (resp_ready) begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM / block outputs
    // ------------------------------------------------------------------
    always_comb begin
        inst_valid       = (state_q == c_ISSUE);
        scalar_pro_ready = (state_q == c_WAIT_ACK);
        resp_valid       = (state_q == c_RESP);
        busy             = (state_q != c_IDLE) || (count_q != '0);
        enq_ready        = !w_full;
        count            = count_q;
        instruction      = instr_q;
        rs1_data         = rs1_q;
        rs2_data         = rs2_q;
        resp_error       = resp_error_q;
        resp_illegal     = resp_illegal_q;
        resp_timeout     = resp_timeout_q;
    end

    // ------------------------------------------------------------------
    // FIFO, issue registers, timeout counter and response capture
    // ------------------------------------------------------------------
    always_comb begin
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        instr_d        = instr_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        resp_error_d   = resp_error_q;
        resp_illegal_d = resp_illegal_q;
        resp_timeout_d = resp_timeout_q;

        // Held at zero outside WAIT_ACK, so it restarts on every entry.
        timer_d = (state_q == c_WAIT_ACK) ? (timer_q + c_TW'(1)) : '0;

        if (w_push) begin
            mem_d[wr_ptr_q] = {enq_instruction, enq_rs1_data, enq_rs2_data};
            wr_ptr_d        = wr_ptr_q + c_AW'(1);
        end

        if (w_pop) begin
            {instr_d, rs1_d, rs2_d} = mem_q[rd_ptr_q];
            rd_ptr_d                = rd_ptr_q + c_AW'(1);
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CW'(1);
            2'b01:   count_d = count_q - c_CW'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        // An ack on the final timeout cycle still reports the ack.
        if (w_ack) begin
            resp_error_d   = error;
            resp_illegal_d = !is_vec;
            resp_timeout_d = 1'b0;
        end else if (w_expire) begin
            resp_error_d   = 1'b0;
            resp_illegal_d = 1'b0;
            resp_timeout_d = 1'b1;
        end else if ((state_q == c_RESP) && resp_ready) begin
            resp_error_d   = 1'b0;
            resp_illegal_d = 1'b0;
            resp_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q          <= '{default: '0};
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            timer_q        <= '0;
            instr_q        <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            resp_error_q   <= 1'b0;
            resp_illegal_q <= 1'b0;
            resp_timeout_q <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            timer_q        <= timer_d;
            instr_q        <= instr_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            resp_error_q   <= resp_error_d;
            resp_illegal_q <= resp_illegal_d;
            resp_timeout_q <= resp_timeout_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vec_inst_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_inst_dispatch
//  Description : Self-checking bench for vec_inst_dispatch with a queue-based
//                reference model of FIFO order and response outcomes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_inst_dispatch;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int EW    = 3 * XLEN;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enq_valid = 1'b0;
    logic            enq_ready;
    logic [XLEN-1:0] enq_instruction = '0;
    logic [XLEN-1:0] enq_rs1_data = '0;
    logic [XLEN-1:0] enq_rs2_data = '0;
    logic            flush = 1'b0;
    logic            inst_valid;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            vec_pro_ready = 1'b0;
    logic            vec_pro_ack = 1'b0;
    logic            is_vec = 1'b0;
    logic            error = 1'b0;
    logic            scalar_pro_ready;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic            resp_error;
    logic            resp_illegal;
    logic            resp_timeout;
    logic            busy;
    logic [CW-1:0]   count;

    vec_inst_dispatch #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_instruction(enq_instruction), .enq_rs1_data(enq_rs1_data), .enq_rs2_data(enq_rs2_data),
        .flush(flush),
        .inst_valid(inst_valid), .instruction(instruction), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .vec_pro_ready(vec_pro_ready), .vec_pro_ack(vec_pro_ack), .is_vec(is_vec), .error(error),
        .scalar_pro_ready(scalar_pro_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_error(resp_error), .resp_illegal(resp_illegal), .resp_timeout(resp_timeout),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: queued entries, expected issue order, expected responses.
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_issue[$];
    logic [EW-1:0] act_issue[$];
    logic [2:0]    exp_resp[$];
    logic [2:0]    act_resp[$];
    bit            in_wait = 1'b0;
    int            wait_n = 0;
    bit            last_acc = 1'b0;

    task automatic step();
        bit            acc, fl, hs, ackc, rsp, was_iv;
        logic [2:0]    ackv;
        logic [EW-1:0] din;
        acc    = reset && enq_valid && enq_ready && !flush;
        fl     = flush;
        hs     = inst_valid && vec_pro_ready;
        ackc   = in_wait && vec_pro_ack;
        ackv   = {error, !is_vec, 1'b0};
        rsp    = resp_valid && resp_ready;
        was_iv = inst_valid;
        din    = {enq_instruction, enq_rs1_data, enq_rs2_data};
        if (rsp) act_resp.push_back({resp_error, resp_illegal, resp_timeout});
        @(posedge clk);
        #1;
        last_acc = acc;
        if (!reset) begin
            exp_q.delete();
            in_wait = 1'b0;
            return;
        end
        if (!was_iv && inst_valid) begin
            if (exp_q.size() > 0) exp_issue.push_back(exp_q.pop_front());
            else exp_issue.push_back('x);
            act_issue.push_back({instruction, rs1_data, rs2_data});
        end
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(din);
        if (in_wait) begin
            wait_n++;
            if (ackc) begin
                exp_resp.push_back(ackv);
                in_wait = 1'b0;
            end else if (wait_n == TMO) begin
                exp_resp.push_back(3'b001);
                in_wait = 1'b0;
            end
        end
        if (hs) begin
            in_wait = 1'b1;
            wait_n  = 0;
        end
    endtask

    task automatic do_reset();
        enq_valid = 0; flush = 0; vec_pro_ready = 0; vec_pro_ack = 0;
        is_vec = 0; error = 0; resp_ready = 0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        in_wait = 1'b0;
        wait_n  = 0;
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic issue_to_resp(input logic [XLEN-1:0] ins, input bit err, input bit isv, output bit ok);
        int n;
        enq_valid = 1'b1; enq_instruction = ins;
        enq_rs1_data = $urandom; enq_rs2_data = $urandom;
        vec_pro_ready = 1'b1;
        step();
        enq_valid = 1'b0;
        n = 0;
        while (!scalar_pro_ready && n < 10) begin step(); n++; end
        vec_pro_ack = 1'b1; error = err; is_vec = isv;
        step();
        vec_pro_ack = 1'b0; error = 1'b0; is_vec = 1'b0;
        ok = resp_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        tests++;
        if (inst_valid !== 1'b0 || scalar_pro_ready !== 1'b0 || resp_valid !== 1'b0) begin
            fails++; $display("FAIL reset_strobes: iv=%b spr=%b rv=%b expected 0 0 0", inst_valid, scalar_pro_ready, resp_valid);
        end
        tests++;
        if (enq_ready !== 1'b1) begin fails++; $display("FAIL reset_enq_ready: got %b expected 1", enq_ready); end
        tests++;
        if (count !== '0 || busy !== 1'b0) begin fails++; $display("FAIL reset_count_busy: count=%0d busy=%b expected 0 0", count, busy); end
        tests++;
        if ({instruction, rs1_data, rs2_data} !== '0) begin fails++; $display("FAIL reset_data: got %h expected 0", {instruction, rs1_data, rs2_data}); end
        tests++;
        if ({resp_error, resp_illegal, resp_timeout} !== 3'b000) begin
            fails++; $display("FAIL reset_flags: got %b expected 000", {resp_error, resp_illegal, resp_timeout});
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_single_issue();
        vec_pro_ready = 1'b1;
        enq_valid = 1'b1; enq_instruction = 32'h0000_0057; enq_rs1_data = 32'h10; enq_rs2_data = 32'h20;
        step();
        enq_valid = 1'b0;
        tests++;
        if (inst_valid !== 1'b0 || count !== CW'(1)) begin fails++; $display("FAIL single_after_push: iv=%b count=%0d expected 0 1", inst_valid, count); end
        step();
        tests++;
        if (inst_valid !== 1'b1) begin fails++; $display("FAIL single_latency: iv=%b expected 1", inst_valid); end
        tests++;
        if ({instruction, rs1_data, rs2_data} !== {32'h57, 32'h10, 32'h20}) begin
            fails++; $display("FAIL single_operands: got %h expected %h", {instruction, rs1_data, rs2_data}, {32'h57, 32'h10, 32'h20});
        end
        step();
        tests++;
        if (inst_valid !== 1'b0 || scalar_pro_ready !== 1'b1) begin
            fails++; $display("FAIL single_handshake: iv=%b spr=%b expected 0 1", inst_valid, scalar_pro_ready);
        end
        step(); step();
        vec_pro_ack = 1'b1; is_vec = 1'b1; error = 1'b0;
        step();
        vec_pro_ack = 1'b0; is_vec = 1'b0;
        tests++;
        if (resp_valid !== 1'b1 || {resp_error, resp_illegal, resp_timeout} !== 3'b000) begin
            fails++; $display("FAIL single_resp: rv=%b flags=%b expected 1 000", resp_valid, {resp_error, resp_illegal, resp_timeout});
        end
        consume();
        tests++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin fails++; $display("FAIL single_idle: busy=%b rv=%b expected 0 0", busy, resp_valid); end
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] d;
        int extra;
        d = {$urandom, $urandom, $urandom};
        vec_pro_ready = 1'b0;
        enq_valid = 1'b1; {enq_instruction, enq_rs1_data, enq_rs2_data} = d;
        step();
        enq_valid = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (inst_valid !== 1'b1 || {instruction, rs1_data, rs2_data} !== d) begin
                fails++; $display("FAIL bp_hold[%0d]: iv=%b data=%h expected 1 %h", c, inst_valid, {instruction, rs1_data, rs2_data}, d);
            end
            {enq_instruction, enq_rs1_data, enq_rs2_data} = {$urandom, $urandom, $urandom};
            step();
        end
        vec_pro_ready = 1'b1;
        step();
        tests++;
        if (inst_valid !== 1'b0 || scalar_pro_ready !== 1'b1) begin
            fails++; $display("FAIL bp_release: iv=%b spr=%b expected 0 1", inst_valid, scalar_pro_ready);
        end
        extra = 0;
        for (int c = 0; c < 3; c++) begin
            if (inst_valid) extra++;
            step();
        end
        tests++;
        if (extra !== 0) begin fails++; $display("FAIL bp_single_handshake: extra valid cycles=%0d expected 0", extra); end
        vec_pro_ack = 1'b1; is_vec = 1'b1;
        step();
        vec_pro_ack = 1'b0; is_vec = 1'b0;
        consume();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL bp_idle: busy=%b expected 0", busy); end
    endtask

    task automatic test_full_wrap();
        int acc, n;
        exp_issue.delete(); act_issue.delete();
        vec_pro_ready = 1'b0; vec_pro_ack = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            enq_valid = 1'b1;
            enq_instruction = 32'hA000_0000 + 32'(k);
            enq_rs1_data = $urandom; enq_rs2_data = $urandom;
            n = 0;
            do begin step(); n++; end while (!last_acc && n < 3);
            if (last_acc) acc++;
        end
        tests++;
        if (acc !== 5) begin fails++; $display("FAIL full_accepted: got %0d expected 5", acc); end
        tests++;
        if (count !== CW'(4) || enq_ready !== 1'b0) begin fails++; $display("FAIL full_state: count=%0d enq_ready=%b expected 4 0", count, enq_ready); end
        vec_pro_ready = 1'b1; vec_pro_ack = 1'b1; is_vec = 1'b1; error = 1'b0; resp_ready = 1'b1;
        n = 0;
        while ((busy || enq_valid) && n < 80) begin
            step(); n++;
            if (last_acc) enq_valid = 1'b0;
        end
        vec_pro_ack = 1'b0; is_vec = 1'b0; resp_ready = 1'b0; enq_valid = 1'b0;
        tests++;
        if (busy !== 1'b0 || count !== '0) begin fails++; $display("FAIL full_drain: busy=%b count=%0d expected 0 0", busy, count); end
        tests++;
        if (act_issue.size() !== 6 || exp_issue.size() !== 6) begin
            fails++; $display("FAIL full_issue_count: got %0d expected %0d (6)", act_issue.size(), exp_issue.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests++;
                if (act_issue[i] !== exp_issue[i]) begin fails++; $display("FAIL full_order[%0d]: got %h expected %h", i, act_issue[i], exp_issue[i]); end
            end
        end
    endtask

    task automatic test_error_illegal();
        bit ok;
        issue_to_resp(32'h0000_1057, 1'b1, 1'b0, ok);
        tests++;
        if (!ok || {resp_error, resp_illegal, resp_timeout} !== 3'b110) begin
            fails++; $display("FAIL err_ill_flags: rv=%b flags=%b expected 1 110", ok, {resp_error, resp_illegal, resp_timeout});
        end
        consume();
        issue_to_resp(32'h0000_2057, 1'b0, 1'b1, ok);
        tests++;
        if (!ok || {resp_error, resp_illegal, resp_timeout} !== 3'b000) begin
            fails++; $display("FAIL err_clean_flags: rv=%b flags=%b expected 1 000", ok, {resp_error, resp_illegal, resp_timeout});
        end
        consume();
        tests++;
        if ({resp_error, resp_illegal, resp_timeout} !== 3'b000) begin
            fails++; $display("FAIL err_cleared: flags=%b expected 000", {resp_error, resp_illegal, resp_timeout});
        end
    endtask

    task automatic test_timeout();
        int n;
        vec_pro_ready = 1'b1;
        enq_valid = 1'b1; enq_instruction = 32'h0000_3057;
        step();
        enq_valid = 1'b0;
        n = 0;
        while (!scalar_pro_ready && n < 10) begin step(); n++; end
        n = 0;
        while (!resp_valid && n < 40) begin
            if (!scalar_pro_ready) break;
            step(); n++;
        end
        tests++;
        if (n !== TMO || resp_valid !== 1'b1) begin fails++; $display("FAIL tmo_latency: cycles=%0d rv=%b expected %0d 1", n, resp_valid, TMO); end
        tests++;
        if ({resp_error, resp_illegal, resp_timeout} !== 3'b001) begin
            fails++; $display("FAIL tmo_flags: got %b expected 001", {resp_error, resp_illegal, resp_timeout});
        end
        vec_pro_ack = 1'b1; error = 1'b1; is_vec = 1'b0;
        step();
        tests++;
        if (resp_valid !== 1'b1 || {resp_error, resp_illegal, resp_timeout} !== 3'b001) begin
            fails++; $display("FAIL tmo_late_ack: rv=%b flags=%b expected 1 001", resp_valid, {resp_error, resp_illegal, resp_timeout});
        end
        vec_pro_ack = 1'b0; error = 1'b0;
        consume();
        vec_pro_ack = 1'b1;
        step(); step();
        vec_pro_ack = 1'b0;
        tests++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin fails++; $display("FAIL tmo_idle_ack: busy=%b rv=%b expected 0 0", busy, resp_valid); end
    endtask

    task automatic test_flush();
        int seen;
        exp_issue.delete(); act_issue.delete();
        vec_pro_ready = 1'b1;
        enq_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            enq_instruction = 32'hF000_0000 + 32'(k);
            enq_rs1_data = $urandom; enq_rs2_data = $urandom;
            step();
        end
        tests++;
        if (count !== CW'(3) || scalar_pro_ready !== 1'b1) begin
            fails++; $display("FAIL flush_setup: count=%0d spr=%b expected 3 1", count, scalar_pro_ready);
        end
        enq_instruction = 32'hF000_00EE;
        flush = 1'b1;
        step();
        flush = 1'b0; enq_valid = 1'b0;
        tests++;
        if (count !== '0 || enq_ready !== 1'b1) begin fails++; $display("FAIL flush_count: count=%0d enq_ready=%b expected 0 1", count, enq_ready); end
        tests++;
        if (scalar_pro_ready !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL flush_inflight: spr=%b busy=%b expected 1 1", scalar_pro_ready, busy); end
        vec_pro_ack = 1'b1; is_vec = 1'b1; error = 1'b1;
        step();
        vec_pro_ack = 1'b0; is_vec = 1'b0; error = 1'b0;
        tests++;
        if (resp_valid !== 1'b1 || {resp_error, resp_illegal, resp_timeout} !== 3'b100) begin
            fails++; $display("FAIL flush_resp: rv=%b flags=%b expected 1 100", resp_valid, {resp_error, resp_illegal, resp_timeout});
        end
        consume();
        seen = 0;
        for (int c = 0; c < 4; c++) begin step(); if (inst_valid) seen++; end
        tests++;
        if (seen !== 0 || busy !== 1'b0 || count !== '0) begin
            fails++; $display("FAIL flush_after: issues=%0d busy=%b count=%0d expected 0 0 0", seen, busy, count);
        end
        tests++;
        if (act_issue.size() !== 1 || act_issue[0][EW-1 -: XLEN] !== 32'hF000_0000) begin
            fails++; $display("FAIL flush_issued: n=%0d first=%h expected 1 f0000000", act_issue.size(), act_issue.size() > 0 ? act_issue[0][EW-1 -: XLEN] : 32'h0);
        end
    endtask

    task automatic test_reset_mid_issue();
        vec_pro_ready = 1'b0;
        enq_valid = 1'b1; enq_instruction = 32'h0000_4057;
        step();
        enq_instruction = 32'h0000_5057;
        step();
        enq_valid = 1'b0;
        tests++;
        if (inst_valid !== 1'b1 || count !== CW'(1)) begin fails++; $display("FAIL rst_setup: iv=%b count=%0d expected 1 1", inst_valid, count); end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (inst_valid !== 1'b0 || count !== '0) begin fails++; $display("FAIL rst_async: iv=%b count=%0d expected 0 0", inst_valid, count); end
        tests++;
        if (enq_ready !== 1'b1 || busy !== 1'b0 || instruction !== '0) begin
            fails++; $display("FAIL rst_async_state: enq_ready=%b busy=%b instr=%h expected 1 0 0", enq_ready, busy, instruction);
        end
        exp_q.delete(); in_wait = 1'b0;
        step(); step();
        reset = 1'b1;
        step(); step();
        tests++;
        if (inst_valid !== 1'b0 || count !== '0 || resp_valid !== 1'b0) begin
            fails++; $display("FAIL rst_release: iv=%b count=%0d rv=%b expected 0 0 0", inst_valid, count, resp_valid);
        end
    endtask

    task automatic test_random();
        int n;
        exp_issue.delete(); act_issue.delete(); exp_resp.delete(); act_resp.delete();
        for (int c = 0; c < 400; c++) begin
            enq_valid = ($urandom % 2) == 0;
            enq_instruction = $urandom; enq_rs1_data = $urandom; enq_rs2_data = $urandom;
            flush = ($urandom % 40) == 0;
            vec_pro_ready = ($urandom % 3) != 0;
            vec_pro_ack = ($urandom % 6) == 0;
            is_vec = ($urandom % 4) != 0;
            error = ($urandom % 5) == 0;
            resp_ready = ($urandom % 2) == 0;
            step();
            tests++;
            if (count !== CW'(exp_q.size())) begin fails++; $display("FAIL rand_count[%0d]: got %0d expected %0d", c, count, exp_q.size()); end
        end
        enq_valid = 1'b0; flush = 1'b0; vec_pro_ready = 1'b1; resp_ready = 1'b1;
        n = 0;
        while ((busy || in_wait) && n < 2000) begin
            vec_pro_ack = ($urandom % 4) == 0;
            is_vec = ($urandom % 2) == 0;
            error = ($urandom % 2) == 0;
            step(); n++;
        end
        vec_pro_ack = 1'b0; resp_ready = 1'b0;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL rand_drain: busy=%b after %0d cycles expected 0", busy, n); end
        tests++;
        if (act_issue.size() !== exp_issue.size()) begin
            fails++; $display("FAIL rand_issue_count: got %0d expected %0d", act_issue.size(), exp_issue.size());
        end else begin
            foreach (exp_issue[i]) begin
                tests++;
                if (act_issue[i] !== exp_issue[i]) begin fails++; $display("FAIL rand_issue[%0d]: got %h expected %h", i, act_issue[i], exp_issue[i]); end
            end
        end
        tests++;
        if (act_resp.size() !== exp_resp.size()) begin
            fails++; $display("FAIL rand_resp_count: got %0d expected %0d", act_resp.size(), exp_resp.size());
        end else begin
            foreach (exp_resp[i]) begin
                tests++;
                if (act_resp[i] !== exp_resp[i]) begin fails++; $display("FAIL rand_resp[%0d]: got %b expected %b", i, act_resp[i], exp_resp[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_backpressure();
        test_full_wrap();
        test_error_illegal();
        test_timeout();
        test_flush();
        test_reset_mid_issue();
        do_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
